// File: rtl/cap_tag_pkg.sv
// Shared types and constants for the capability-tag arbiter.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cap_tag_pkg;

    localparam int TIMEOUT_DFLT = 1023;
    localparam int WAIT_W       = 10;

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        COMMIT,
        TAGS1,
        TAGS2,
        DONE
    } e_state;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WR,
        OP_WR_CAP,
        OP_TAGS
    } e_op;

    // Priority when several op bits are set: wr_cap, then wr, then load_tags.
    function automatic e_op decode_op(input logic wr, input logic wr_cap, input logic load_tags);
        e_op op;
        op = OP_READ;
        if (load_tags) op = OP_TAGS;
        if (wr)        op = OP_WR;
        if (wr_cap)    op = OP_WR_CAP;
        return op;
    endfunction

endpackage

// File: rtl/cap_tag_arbiter_if.sv
// Requester and cache-side signal bundle for cap_tag_arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until their ack pulse.
// Ports: master = arbiter side (drives ack/tag results and cache commands),
//        slave  = environment side (requesters plus cache responses).
interface cap_tag_arbiter_if #(
    parameter int NREQ = 2,
    parameter int WID  = 64
);
    // requester side
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        wr;
    logic [NREQ-1:0]        wr_cap;
    logic [NREQ-1:0]        load_tags;
    logic [NREQ-1:0][31:0]  adr;
    logic [NREQ-1:0]        tagi;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        tago;
    logic [WID-1:0]         tagso;
    logic                   timeout_err;
    logic                   busy;
    // cache side
    logic                   cache_wr;
    logic                   cache_wr_cap;
    logic                   cache_load_tags;
    logic [31:0]            cache_adr;
    logic                   cache_tagi;
    logic                   cache_hit;
    logic                   cache_tago;
    logic [WID-1:0]         cache_tagso;

    modport master (
        input  req, wr, wr_cap, load_tags, adr, tagi,
        input  cache_hit, cache_tago, cache_tagso,
        output ack, tago, tagso, timeout_err, busy,
        output cache_wr, cache_wr_cap, cache_load_tags, cache_adr, cache_tagi
    );

    modport slave (
        output req, wr, wr_cap, load_tags, adr, tagi,
        output cache_hit, cache_tago, cache_tagso,
        input  ack, tago, tagso, timeout_err, busy,
        input  cache_wr, cache_wr_cap, cache_load_tags, cache_adr, cache_tagi
    );

endinterface

// File: rtl/cap_tag_arbiter_rr.sv
// Round-robin selector: one-hot grant among req_i, searching from ptr_q.
// Latency: grant is combinational; pointer moves one cycle after adv_i.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: clk/rst, req_i (NREQ), gnt_o (one-hot), adv_i + adv_gnt_i (served requester).
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    input  logic            adv_i,
    input  logic [NREQ-1:0] adv_gnt_i
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    // Walk offsets from high to low so the smallest offset from ptr_q wins.
    always_comb begin
        gnt_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

    // Next search starts one past the requester that was just served.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            for (int i = 0; i < NREQ; i++) begin
                if (adv_gnt_i[i]) ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cap_tag_arbiter.sv
// Arbitrates NREQ requesters onto one tagged cache: probe, then read / commit / tag-set load.
// Latency: grant -> PROBE 1 cycle; read ack 1 cycle after hit, write 2, load_tags 3; miss times out.
// Backpressure: one op in flight; req held until ack, at least one IDLE cycle between ops.
// Ports: clk, rst (sync, active-high), bus (cap_tag_arbiter_if.master: requester + cache signals).
module cap_tag_arbiter
    import cap_tag_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WID     = 64,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    cap_tag_arbiter_if.master  bus
);
    e_state             state_q;
    e_op                op_q;
    logic [NREQ-1:0]    own_q;
    logic               tagi_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [NREQ-1:0]    ack_q;
    logic [NREQ-1:0]    tago_q;
    logic [WID-1:0]     tagso_q;
    logic               timeout_err_q;
    logic               busy_q;
    logic               cache_wr_q;
    logic               cache_wr_cap_q;
    logic               cache_lt_q;
    logic [31:0]        cache_adr_q;
    logic               cache_tagi_q;

    logic [NREQ-1:0]    gnt;
    logic               sel_wr, sel_wr_cap, sel_lt, sel_tagi;
    logic [31:0]        sel_adr;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req),
        .gnt_o     (gnt),
        .adv_i     (state_q == DONE),
        .adv_gnt_i (own_q)
    );

    // Pick the granted requester's command fields.
    always_comb begin
        sel_wr     = 1'b0;
        sel_wr_cap = 1'b0;
        sel_lt     = 1'b0;
        sel_tagi   = 1'b0;
        sel_adr    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_wr     = bus.wr[i];
                sel_wr_cap = bus.wr_cap[i];
                sel_lt     = bus.load_tags[i];
                sel_tagi   = bus.tagi[i];
                sel_adr    = bus.adr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= OP_READ;
            own_q          <= '0;
            tagi_q         <= 1'b0;
            wait_q         <= '0;
            ack_q          <= '0;
            tago_q         <= '0;
            tagso_q        <= '0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
            cache_wr_q     <= 1'b0;
            cache_wr_cap_q <= 1'b0;
            cache_lt_q     <= 1'b0;
            cache_adr_q    <= '0;
            cache_tagi_q   <= 1'b0;
        end else begin
            // Pulses default low; each state raises only what it needs.
            ack_q          <= '0;
            timeout_err_q  <= 1'b0;
            cache_wr_q     <= 1'b0;
            cache_wr_cap_q <= 1'b0;
            cache_lt_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        op_q        <= decode_op(sel_wr, sel_wr_cap, sel_lt);
                        own_q       <= gnt;
                        tagi_q      <= sel_tagi;
                        cache_adr_q <= sel_adr;
                        wait_q      <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= PROBE;
                    end
                end
                PROBE: begin
                    if (bus.cache_hit) begin
                        case (op_q)
                            OP_READ: begin
                                tago_q  <= (tago_q & ~own_q) | (own_q & {NREQ{bus.cache_tago}});
                                ack_q   <= own_q;
                                state_q <= DONE;
                            end
                            OP_WR: begin
                                cache_wr_q   <= 1'b1;
                                cache_tagi_q <= tagi_q;
                                state_q      <= COMMIT;
                            end
                            OP_WR_CAP: begin
                                cache_wr_cap_q <= 1'b1;
                                cache_tagi_q   <= tagi_q;
                                state_q        <= COMMIT;
                            end
                            default: begin
                                cache_lt_q <= 1'b1;
                                state_q    <= TAGS1;
                            end
                        endcase
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        // This miss cycle brings the count to TIMEOUT: give up.
                        wait_q        <= wait_q + 1'b1;
                        timeout_err_q <= 1'b1;
                        ack_q         <= own_q;
                        tago_q        <= tago_q & ~own_q;
                        state_q       <= DONE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                COMMIT: begin
                    ack_q   <= own_q;
                    state_q <= DONE;
                end
                TAGS1: begin
                    state_q <= TAGS2;
                end
                TAGS2: begin
                    tagso_q <= bus.cache_tagso;
                    ack_q   <= own_q;
                    state_q <= DONE;
                end
                DONE: begin
                    // No grant here: forces an IDLE cycle between operations.
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack             = ack_q;
    assign bus.tago            = tago_q;
    assign bus.tagso           = tagso_q;
    assign bus.timeout_err     = timeout_err_q;
    assign bus.busy            = busy_q;
    assign bus.cache_wr        = cache_wr_q;
    assign bus.cache_wr_cap    = cache_wr_cap_q;
    assign bus.cache_load_tags = cache_lt_q;
    assign bus.cache_adr       = cache_adr_q;
    assign bus.cache_tagi      = cache_tagi_q;

endmodule

// File: tb/tb_cap_tag_arbiter.sv
// Scoreboarded bench for cap_tag_arbiter: directed ops push expected acks,
// a negedge monitor pops and compares each ack and counts cache strobes.
module tb_cap_tag_arbiter;
    localparam int NREQ = 2;
    localparam int WID  = 64;
    localparam int TO   = 12;
    localparam logic [63:0] TAGSET = 64'hDEAD_BEEF_0000_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cap_tag_arbiter_if #(.NREQ(NREQ), .WID(WID)) bus ();

    cap_tag_arbiter #(.NREQ(NREQ), .WID(WID), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int             idx;
        logic           tago;
        logic           chk_tagso;
        logic [WID-1:0] tagso;
        logic           to;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int n_total = 0, n_pass = 0;
    int cnt_wr = 0, cnt_wrcap = 0, cnt_lt = 0, cnt_to = 0;
    logic last_tagi = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            tick();
            cyc++;
            got = |bus.ack;
        end
        if (!got) chk("ack_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic push(input int idx, input logic tago, input logic ct, input logic [WID-1:0] ts, input logic to);
        exp_t x;
        x.idx = idx; x.tago = tago; x.chk_tagso = ct; x.tagso = ts; x.to = to;
        exp_q.push_back(x);
    endtask

    task automatic clr_req();
        bus.req = '0; bus.wr = '0; bus.wr_cap = '0; bus.load_tags = '0; bus.tagi = '0;
    endtask

    // Monitor: strobe accounting and ack scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cache_wr === 1'b1) cnt_wr++;
            if (bus.cache_wr_cap === 1'b1) begin
                cnt_wrcap++;
                last_tagi = bus.cache_tagi;
            end
            if (bus.cache_load_tags === 1'b1) cnt_lt++;
            if (bus.timeout_err === 1'b1) cnt_to++;
            if (|bus.ack) begin
                chk("ack_onehot", 64'($onehot(bus.ack)), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 64'(bus.ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_idx", 64'(bus.ack), 64'd1 << e.idx);
                    chk("ack_tago", 64'(bus.tago[e.idx]), 64'(e.tago));
                    chk("ack_timeout_err", 64'(bus.timeout_err), 64'(e.to));
                    if (e.chk_tagso) chk("ack_tagso", bus.tagso, e.tagso);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc, s_wr, s_wc, s_lt;
        rst = 1'b1;
        clr_req();
        bus.adr = '0;
        bus.cache_hit = 1'b0; bus.cache_tago = 1'b0; bus.cache_tagso = '0;
        repeat (3) tick();
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pulses", 64'({bus.cache_wr, bus.cache_wr_cap, bus.cache_load_tags, bus.timeout_err}), 64'd0);
        chk("rst_cache_adr", 64'(bus.cache_adr), 64'd0);
        chk("rst_tago", 64'(bus.tago), 64'd0);
        chk("rst_tagso", bus.tagso, 64'd0);
        rst = 1'b0;
        tick();

        // Single read from requester 0, hit arrives one cycle into PROBE.
        bus.adr[0] = 32'h2000_0400; bus.cache_tago = 1'b1; bus.req = 2'b01;
        push(0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        chk("rd_busy", 64'(bus.busy), 64'd1);
        chk("rd_cache_adr", 64'(bus.cache_adr), 64'h2000_0400);
        chk("rd_ack_early", 64'(bus.ack), 64'd0);
        bus.cache_hit = 1'b1;
        tick();
        chk("rd_ack_latency", 64'(bus.ack), 64'b01);
        clr_req();
        tick();
        chk("rd_no_strobes", 64'(cnt_wr + cnt_wrcap + cnt_lt), 64'd0);

        // Capability write from requester 1.
        bus.adr[1] = 32'h3000_0080; bus.cache_tago = 1'b0;
        bus.req = 2'b10; bus.wr_cap = 2'b10; bus.tagi = 2'b10;
        push(1, 1'b0, 1'b0, '0, 1'b0);
        cyc = 0;
        do begin tick(); cyc++; end while (bus.cache_wr_cap !== 1'b1 && cyc < 10);
        chk("cw_strobe_seen", 64'(bus.cache_wr_cap), 64'd1);
        chk("cw_tagi", 64'(bus.cache_tagi), 64'd1);
        chk("cw_cache_adr", 64'(bus.cache_adr), 64'h3000_0080);
        tick();
        chk("cw_pulse_len", 64'(bus.cache_wr_cap), 64'd0);
        chk("cw_ack", 64'(bus.ack), 64'b10);
        clr_req();
        tick();
        chk("cw_count", 64'(cnt_wrcap), 64'd1);
        chk("cw_no_wr", 64'(cnt_wr), 64'd0);

        // Contention: both requesters held, expect 0,1,0,1.
        bus.cache_tago = 1'b1; bus.req = 2'b11;
        push(0, 1'b1, 1'b0, '0, 1'b0);
        push(1, 1'b1, 1'b0, '0, 1'b0);
        push(0, 1'b1, 1'b0, '0, 1'b0);
        push(1, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(20, cyc);
            if (k == 3) clr_req();
            tick();
            chk("ct_idle_gap", 64'(bus.busy), 64'd0);
        end

        // Tag-set load from requester 0.
        s_lt = cnt_lt;
        bus.cache_tagso = TAGSET; bus.req = 2'b01; bus.load_tags = 2'b01;
        push(0, 1'b1, 1'b1, TAGSET, 1'b0);
        wait_ack(20, cyc);
        chk("lt_latency", 64'(cyc), 64'd4);
        clr_req();
        bus.cache_tagso = 64'h1234_5678_9ABC_DEF0;
        tick();
        chk("lt_pulses", 64'(cnt_lt - s_lt), 64'd1);

        // Precedence: wr_cap over wr over load_tags.
        s_wr = cnt_wr; s_wc = cnt_wrcap; s_lt = cnt_lt;
        bus.req = 2'b01; bus.wr = 2'b01; bus.wr_cap = 2'b01; bus.load_tags = 2'b01;
        push(0, 1'b1, 1'b0, '0, 1'b0);
        wait_ack(20, cyc);
        clr_req();
        tick();
        chk("pr1_wrcap", 64'(cnt_wrcap - s_wc), 64'd1);
        chk("pr1_wr", 64'(cnt_wr - s_wr), 64'd0);
        chk("pr1_lt", 64'(cnt_lt - s_lt), 64'd0);
        s_wr = cnt_wr; s_wc = cnt_wrcap; s_lt = cnt_lt;
        bus.req = 2'b10; bus.wr = 2'b10; bus.load_tags = 2'b10;
        push(1, 1'b1, 1'b0, '0, 1'b0);
        wait_ack(20, cyc);
        clr_req();
        tick();
        chk("pr2_wr", 64'(cnt_wr - s_wr), 64'd1);
        chk("pr2_wrcap", 64'(cnt_wrcap - s_wc), 64'd0);
        chk("pr2_lt", 64'(cnt_lt - s_lt), 64'd0);
        chk("tagso_hold", bus.tagso, TAGSET);

        // Timeout: cache never hits.
        s_wr = cnt_wr; s_wc = cnt_wrcap;
        bus.cache_hit = 1'b0; bus.cache_tago = 1'b1; bus.req = 2'b01;
        push(0, 1'b0, 1'b0, '0, 1'b1);
        wait_ack(TO + 10, cyc);
        chk("to_latency", 64'(cyc), 64'(TO + 1));
        clr_req();
        tick();
        chk("to_idle", 64'(bus.busy), 64'd0);
        chk("to_no_write", 64'((cnt_wr - s_wr) + (cnt_wrcap - s_wc)), 64'd0);
        chk("to_err_count", 64'(cnt_to), 64'd1);

        // Reset while in COMMIT: strobe drops, no ack.
        bus.cache_hit = 1'b1; bus.req = 2'b10; bus.wr = 2'b10;
        cyc = 0;
        do begin tick(); cyc++; end while (bus.cache_wr !== 1'b1 && cyc < 10);
        chk("rc_commit_seen", 64'(bus.cache_wr), 64'd1);
        rst = 1'b1;
        tick();
        chk("rc_wr_drop", 64'(bus.cache_wr), 64'd0);
        chk("rc_no_ack", 64'(bus.ack), 64'd0);
        chk("rc_busy", 64'(bus.busy), 64'd0);
        chk("rc_tago_clr", 64'(bus.tago), 64'd0);
        clr_req();
        rst = 1'b0;
        tick();
        tick();
        chk("rc_stays_idle", 64'(bus.busy), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
